// File: rtl/pattern_scan_ctrl.sv
// Word-to-serial scan controller with a 2-bit previous/current pattern detector.
// Optional `PATTERN_SCAN_ABORT_EN adds an abort input that cancels a word mid-scan.
module pattern_scan_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1),
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
`ifdef PATTERN_SCAN_ABORT_EN
    input  logic             abort,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       pattern,
    input  logic             carry_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_hit,
    output logic [IDX_W-1:0] out_first,
    output logic             busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] word;
    logic [1:0]       pat;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] first;
    logic             found;
    logic             prev_bit;
    logic             prev_valid;
    logic             cur;
    logic             match;

    assign cur   = word[idx];
    assign match = prev_valid & (prev_bit == pat[1]) & (cur == pat[0]);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_count = count;
    assign out_hit   = (count != '0);
    assign out_first = first;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            word       <= '0;
            pat        <= '0;
            idx        <= '0;
            count      <= '0;
            first      <= '0;
            found      <= 1'b0;
            prev_bit   <= 1'b0;
            prev_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        word  <= in_data;
                        pat   <= pattern;
                        idx   <= IDX_W'(WIDTH - 1);
                        count <= '0;
                        first <= '0;
                        found <= 1'b0;
                        if (!carry_en)
                            prev_valid <= 1'b0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
`ifdef PATTERN_SCAN_ABORT_EN
                    if (abort) begin
                        prev_valid <= 1'b0;
                        state      <= IDLE;
                    end else
`endif
                    begin
                        if (match) begin
                            count <= count + CNT_W'(1);
                            if (!found) begin
                                first <= idx;
                                found <= 1'b1;
                            end
                        end
                        prev_bit   <= cur;
                        prev_valid <= 1'b1;
                        if (idx == '0)
                            state <= DONE;
                        else
                            idx <= idx - IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
